// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - melody ROM player with pause, tempo scaling, loop and learn modes
module melody_sequencer #(
  parameter int ADDR_W     = 9,
  parameter int TICK_DIV   = 100000,
  parameter int BEAT_TICKS = 500,
  parameter int GAP_TICKS  = 50
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_pause,
  input  logic [1:0]        i_mode,
  input  logic [1:0]        i_tempo,
  input  logic [ADDR_W-1:0] i_song_base,
  input  logic [ADDR_W-1:0] i_song_len,
  input  logic              i_key_match,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [6:0]        i_rom_data,
  output logic              o_note_on,
  output logic [2:0]        o_note_deg,
  output logic [1:0]        o_note_oct,
  output logic [ADDR_W-1:0] o_note_idx,
  output logic              o_busy,
  output logic              o_waiting_key,
  output logic              o_done
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Longest note is a half note at half speed: 4 beats.
  localparam int CNT_W = $clog2(4 * BEAT_TICKS + 1);
  localparam logic [1:0] MODE_LEARN = 2'd1;
  localparam logic [1:0] MODE_LOOP  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_GAP, S_SOUND, S_NEXT, S_WAIT_KEY, S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [PRE_W-1:0]   r_presc;
  logic [CNT_W-1:0]   r_cnt, r_snd;
  logic [CNT_W-1:0]   w_dur_base, w_dur, w_snd;
  logic [ADDR_W-1:0]  r_base, r_len, r_idx, r_rom_addr;
  logic [ADDR_W-1:0]  w_idx_nxt;
  logic [1:0]         r_mode;
  logic [2:0]         r_deg;
  logic [1:0]         r_oct;
  logic               r_done;
  logic               w_tick, w_last, w_cnt_one, w_advance, w_finish;

  assign w_tick    = (r_presc == PRE_W'(TICK_DIV - 1)) && !i_pause;
  assign w_last    = (r_idx == r_len - ADDR_W'(1));
  assign w_idx_nxt = w_last ? '0 : r_idx + ADDR_W'(1);
  assign w_cnt_one = (r_cnt == CNT_W'(1));
  assign w_finish  = w_advance && w_last && (r_mode != MODE_LOOP);

  // Note duration in ticks from the ROM word, scaled by the current tempo.
  always_comb begin
    w_dur_base = CNT_W'(BEAT_TICKS);
    case (i_rom_data[6:5])
      2'd0:    w_dur_base = CNT_W'(BEAT_TICKS / 2);
      2'd1:    w_dur_base = CNT_W'(BEAT_TICKS);
      2'd2:    w_dur_base = CNT_W'(BEAT_TICKS / 4);
      default: w_dur_base = CNT_W'(2 * BEAT_TICKS);
    endcase
    case (i_tempo)
      2'd1:    w_dur = w_dur_base << 1;
      2'd2:    w_dur = w_dur_base >> 1;
      default: w_dur = w_dur_base;
    endcase
    w_snd = w_dur - CNT_W'(GAP_TICKS);
  end

  // Tick prescaler; frozen while paused, restarted by start/stop.
  always_ff @(posedge i_clk) begin
    if (i_reset)                r_presc <= '0;
    else if (i_pause)           r_presc <= r_presc;
    else if (i_start || i_stop) r_presc <= '0;
    else if (w_tick)            r_presc <= '0;
    else                        r_presc <= r_presc + PRE_W'(1);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; pause freezes everything, stop beats start.
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    if (i_pause) begin
      w_state_nxt = r_state;
    end else if (i_stop) begin
      w_state_nxt = S_IDLE;
    end else if (i_start) begin
      w_state_nxt = (i_song_len == '0) ? S_DONE : S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    w_state_nxt = S_LOAD;
        S_LOAD:     w_state_nxt = S_GAP;
        S_GAP:      if (w_tick && w_cnt_one) w_state_nxt = S_SOUND;
        S_SOUND:    if (w_tick && w_cnt_one) w_state_nxt = S_NEXT;
        S_NEXT:     if (r_mode == MODE_LEARN) w_state_nxt = S_WAIT_KEY;
                    else                      w_advance   = 1'b1;
        S_WAIT_KEY: if (i_key_match) w_advance = 1'b1;
        default:    w_state_nxt = r_state;
      endcase
      if (w_advance) w_state_nxt = w_finish ? S_DONE : S_FETCH;
    end
  end

  // Datapath: song latch, ROM address, note registers and tick counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_base <= '0; r_len <= '0; r_mode <= '0; r_idx <= '0; r_rom_addr <= '0;
      r_deg  <= '0; r_oct <= '0; r_cnt  <= '0; r_snd <= '0; r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!i_pause) begin
        if (i_stop) begin
          r_idx <= '0; r_rom_addr <= '0; r_deg <= '0; r_oct <= '0; r_cnt <= '0;
        end else if (i_start) begin
          r_base <= i_song_base;
          r_len  <= i_song_len;
          r_mode <= i_mode;
          r_idx  <= '0;
          if (i_song_len == '0) r_done     <= 1'b1;
          else                  r_rom_addr <= i_song_base;
        end else begin
          case (r_state)
            S_LOAD: begin
              r_deg <= i_rom_data[2:0];
              r_oct <= i_rom_data[4:3];
              r_cnt <= CNT_W'(GAP_TICKS);
              r_snd <= w_snd;
            end
            S_GAP:   if (w_tick) r_cnt <= w_cnt_one ? r_snd : r_cnt - CNT_W'(1);
            S_SOUND: if (w_tick) r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
          endcase
          if (w_advance) begin
            if (w_finish) begin
              r_done <= 1'b1;
            end else begin
              r_idx      <= w_idx_nxt;
              r_rom_addr <= r_base + w_idx_nxt;
            end
          end
        end
      end
    end
  end

  assign o_rom_addr    = r_rom_addr;
  assign o_note_deg    = r_deg;
  assign o_note_oct    = r_oct;
  assign o_note_idx    = r_idx;
  assign o_done        = r_done;
  assign o_busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_waiting_key = (r_state == S_WAIT_KEY);
  assign o_note_on     = (r_state == S_SOUND) && (r_deg != 3'd0) && (r_oct != 2'd3) && !i_pause;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - directed scoreboard bench for melody_sequencer
module tb_melody_sequencer;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset, start, stop, pause, key_match;
  logic [1:0]    mode, tempo;
  logic [AW-1:0] song_base, song_len;
  logic [AW-1:0] rom_addr;
  logic [6:0]    rom_data;
  logic          note_on, busy, waiting_key, done;
  logic [2:0]    note_deg;
  logic [1:0]    note_oct;
  logic [AW-1:0] note_idx;

  logic [6:0]    rom [0:511];

  int n_checks = 0;
  int n_errors = 0;
  int q_exp[$];
  int q_obs[$];
  int run_len  = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  melody_sequencer #(
    .ADDR_W(AW), .TICK_DIV(2), .BEAT_TICKS(8), .GAP_TICKS(1)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop), .i_pause(pause),
    .i_mode(mode), .i_tempo(tempo), .i_song_base(song_base), .i_song_len(song_len),
    .i_key_match(key_match), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_note_on(note_on), .o_note_deg(note_deg), .o_note_oct(note_oct),
    .o_note_idx(note_idx), .o_busy(busy), .o_waiting_key(waiting_key), .o_done(done)
  );

  always @(posedge clk) rom_data <= rom[rom_addr];

  // Observed side of the scoreboard: note_on pulse widths and done pulses.
  always @(posedge clk) begin
    #2;
    if (note_on) run_len++;
    else if (run_len > 0) begin
      q_obs.push_back(run_len);
      run_len = 0;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    int e, o;
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      o = (q_obs.size() > 0) ? q_obs.pop_front() : -1;
      chk(tag, o, e);
    end
    chk({tag, "_extra"}, q_obs.size(), 0);
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return done;
      1:       return waiting_key;
      2:       return note_on;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input int max);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      seen = sig(which);
    end
    chk(tag, seen, 1);
  endtask

  task automatic start_song(input logic [AW-1:0] b, input logic [AW-1:0] l,
                            input logic [1:0] m, input logic [1:0] t);
    @(negedge clk);
    song_base = b; song_len = l; mode = m; tempo = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int cnt;
    int sum;
    logic [AW-1:0] prev;
    logic [AW-1:0] exp_addr [5];
    logic [AW-1:0] got_addr [$];

    for (int i = 0; i < 512; i++) rom[i] = 7'd0;
    rom[0]      = 7'b01_00_001;   // 1/4 do mid
    rom[1]      = 7'b00_01_010;   // 1/8 re low
    rom[2]      = 7'b00_11_000;   // 1/8 rest
    rom[5]      = 7'b01_00_011;
    rom[6]      = 7'b01_00_011;
    rom[7]      = 7'b01_00_011;
    rom[9'h1FE] = 7'b00_00_011;
    rom[9'h1FF] = 7'b00_00_100;

    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; key_match = 1'b0;
    mode = 2'd0; tempo = 2'd0; song_base = '0; song_len = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {rom_addr, note_on, note_deg, note_oct, note_idx, busy, waiting_key, done}, 0);

    // 1: auto run of three notes
    q_obs.delete(); done_cnt = 0;
    q_exp.push_back(14); q_exp.push_back(6);
    start_song(0, 3, 2'd0, 2'd0);
    chk("t1_busy_start", busy, 1);
    wait_for("t1_done", 0, 400);
    repeat (4) @(negedge clk);
    chk("t1_busy_after", busy, 0);
    chk("t1_done_count", done_cnt, 1);
    chk("t1_hold_deg", note_deg, 0);
    chk("t1_hold_oct", note_oct, 3);
    sb_check("t1_width");

    // 2: learn run waits for key_match
    q_obs.delete(); done_cnt = 0;
    q_exp.push_back(14); q_exp.push_back(6);
    start_song(0, 2, 2'd1, 2'd0);
    wait_for("t2_wait1", 1, 200);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (waiting_key && !done) cnt++;
    end
    chk("t2_hold", cnt, 100);
    chk("t2_idx0", note_idx, 0);
    key_match = 1'b1;
    @(negedge clk);
    key_match = 1'b0;
    chk("t2_idx1", note_idx, 1);
    chk("t2_wk_low", waiting_key, 0);
    key_match = 1'b1;
    @(negedge clk);
    key_match = 1'b0;
    wait_for("t2_wait2", 1, 200);
    chk("t2_stray_key", note_idx, 1);
    key_match = 1'b1;
    @(negedge clk);
    key_match = 1'b0;
    chk("t2_done", done, 1);
    repeat (2) @(negedge clk);
    chk("t2_busy_after", busy, 0);
    sb_check("t2_width");

    // 3: loop run wrapping the ROM address space
    done_cnt = 0;
    exp_addr[0] = 9'h1FE; exp_addr[1] = 9'h1FF; exp_addr[2] = 9'h000;
    exp_addr[3] = 9'h1FE; exp_addr[4] = 9'h1FF;
    start_song(9'h1FE, 3, 2'd2, 2'd0);
    got_addr.delete();
    prev = rom_addr;
    got_addr.push_back(prev);
    for (int i = 0; i < 300 && got_addr.size() < 5; i++) begin
      @(negedge clk);
      if (rom_addr != prev) begin
        prev = rom_addr;
        got_addr.push_back(prev);
      end
    end
    chk("t3_addr_count", got_addr.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("t3_addr", (i < got_addr.size()) ? got_addr[i] : 9'h0AA, exp_addr[i]);
    chk("t3_no_done", done_cnt, 0);
    chk("t3_busy", busy, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t3_stop", {rom_addr, note_on, note_deg, note_oct, note_idx, busy, waiting_key, done}, 0);

    // 4: pause in the middle of a sounding note
    repeat (2) @(negedge clk);
    q_obs.delete();
    start_song(0, 1, 2'd0, 2'd0);
    wait_for("t4_note_on", 2, 100);
    repeat (4) @(negedge clk);
    pause = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (note_on) cnt++;
    end
    chk("t4_pause_quiet", cnt, 0);
    chk("t4_pause_busy", busy, 1);
    pause = 1'b0;
    wait_for("t4_done", 0, 200);
    repeat (2) @(negedge clk);
    sum = 0;
    foreach (q_obs[i]) sum += q_obs[i];
    chk("t4_total", sum, 14);
    chk("t4_segments", q_obs.size(), 2);

    // 5: empty song and start+stop collision
    prev = rom_addr;
    start_song(9'h0AB, 0, 2'd0, 2'd0);
    chk("t5_len0_done", done, 1);
    chk("t5_len0_addr", rom_addr, prev);
    @(negedge clk);
    chk("t5_len0_pulse", done, 0);
    chk("t5_len0_busy", busy, 0);
    start_song(5, 3, 2'd0, 2'd0);
    repeat (3) @(negedge clk);
    chk("t5_busy", busy, 1);
    chk("t5_addr", rom_addr, 5);
    song_base = 9'h010; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("t5_startstop_busy", busy, 0);
    chk("t5_startstop_addr", rom_addr, 0);
    repeat (5) @(negedge clk);
    chk("t5_stays_idle", busy, 0);

    // 6: tempo scaling and reset mid-note
    q_obs.delete();
    q_exp.push_back(30);
    start_song(0, 1, 2'd0, 2'd1);
    wait_for("t6_done_slow", 0, 300);
    repeat (2) @(negedge clk);
    sb_check("t6_width_slow");
    q_exp.push_back(6);
    start_song(0, 1, 2'd0, 2'd2);
    wait_for("t6_done_fast", 0, 300);
    repeat (2) @(negedge clk);
    sb_check("t6_width_fast");
    start_song(5, 3, 2'd0, 2'd0);
    wait_for("t6_note_on", 2, 100);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_reset", {rom_addr, note_on, note_deg, note_oct, note_idx, busy, waiting_key, done}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
